sub_serial: RTL

- Bit-serial subtractor; the inverse-operation companion to the team's bit-serial adder.
- Loads two unsigned WIDTH-bit operands and computes diff = a - b modulo 2^WIDTH, one bit per clock, LSB first, through a single-bit borrow chain.
- Provides a final borrow flag and a done indication.
- Sits beside the serial adder in the arithmetic datapath, for area-constrained accumulate/decrement paths.

---
 rtl/sub_serial.sv | 91 +++++++++
 1 files changed

// File: rtl/sub_serial.sv
// Bit-serial subtractor: computes a - b modulo 2^WIDTH one bit per clock, LSB first,
// through a single-bit borrow chain, with a registered final borrow and a done flag.
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SUB  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    count;
  logic             borrow;
  logic             diff_bit;
  logic             borrow_next;

  // One full-subtractor cell operating on the current LSBs.
  always_comb begin
    diff_bit    = a_reg[0] ^ b_reg[0] ^ borrow;
    borrow_next = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = SUB;
      SUB:     if (count == CW'(WIDTH - 1)) state_next = DONE;
      DONE:    if (en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      out    <= '0;
      count  <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            a_reg  <= a;
            b_reg  <= b;
            out    <= '0;
            count  <= '0;
            borrow <= 1'b0;
          end
        end
        SUB: begin
          // Result bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
          out    <= {diff_bit, out[WIDTH-1:1]};
          borrow <= borrow_next;
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          count  <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign borrow_out = borrow;
  assign done       = (state == DONE);

endmodule
